// File: rtl/dspmac_pipe.sv
// Three-stage pipelined signed multiply-accumulate with CLR/MUL/MAC/MSU/NOP opcodes.
// Define DSPMAC_SAT_EN to clamp MAC/MSU results and drive a sticky overflow flag.
module dspmac_pipe #(
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int ACC_W = 40
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [2:0]              opcode,
    input  logic signed [A_W-1:0]   a_in,
    input  logic signed [B_W-1:0]   b_in,
    output logic signed [ACC_W-1:0] accu_out,
    output logic                    out_valid,
    output logic                    ovf
);

    localparam int P_W = A_W + B_W;
`ifdef DSPMAC_SAT_EN
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`else
    // Wrapping arithmetic only needs the low ACC_W bits of the sum.
    localparam int SUM_W = ACC_W;
`endif

    generate
        if (ACC_W < P_W) begin : g_width_check
            $error("dspmac_pipe: ACC_W must be >= A_W+B_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        OP_CLR = 3'b000,
        OP_MUL = 3'b001,
        OP_MAC = 3'b010,
        OP_NOP = 3'b011,
        OP_MSU = 3'b100
    } op_e;

    // Stage 1: operand capture
    logic                  valid1_q;
    logic [2:0]            op1_q;
    logic signed [A_W-1:0] a1_q;
    logic signed [B_W-1:0] b1_q;

    // Stage 2: registered full-width product
    logic                  valid2_q;
    logic [2:0]            op2_q;
    logic signed [P_W-1:0] p2_q;

    // Stage 3: accumulator
    logic signed [ACC_W-1:0] accu_q, accu_d;
    logic                    out_valid_q;
    logic signed [ACC_W-1:0] pe;
    logic signed [SUM_W-1:0] sum_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_q <= 1'b0;
            op1_q    <= 3'b000;
            a1_q     <= '0;
            b1_q     <= '0;
        end else begin
            valid1_q <= in_valid;
            if (in_valid) begin
                op1_q <= opcode;
                a1_q  <= a_in;
                b1_q  <= b_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid2_q <= 1'b0;
            op2_q    <= 3'b000;
            p2_q     <= '0;
        end else begin
            valid2_q <= valid1_q;
            if (valid1_q) begin
                op2_q <= op1_q;
                p2_q  <= P_W'(a1_q) * P_W'(b1_q);
            end
        end
    end

    assign pe    = ACC_W'(p2_q);
    assign sum_d = (op2_q == OP_MSU) ? (SUM_W'(accu_q) - SUM_W'(pe))
                                     : (SUM_W'(accu_q) + SUM_W'(pe));

`ifdef DSPMAC_SAT_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        accu_d = accu_q;
`ifdef DSPMAC_SAT_EN
        ovf_d  = ovf_q;
`endif
        if (valid2_q) begin
            case (op2_q)
                OP_CLR: begin
                    accu_d = '0;
`ifdef DSPMAC_SAT_EN
                    ovf_d  = 1'b0;
`endif
                end
                OP_MUL: accu_d = pe;
                OP_MAC, OP_MSU: begin
`ifdef DSPMAC_SAT_EN
                    // Top two sum bits disagree only when the result left the ACC_W range.
                    if (sum_d[ACC_W] != sum_d[ACC_W-1]) begin
                        accu_d = sum_d[ACC_W] ? ACC_MIN : ACC_MAX;
                        ovf_d  = 1'b1;
                    end else begin
                        accu_d = sum_d[ACC_W-1:0];
                    end
`else
                    accu_d = sum_d[ACC_W-1:0];
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accu_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            accu_q      <= accu_d;
            out_valid_q <= valid2_q;
        end
    end

`ifdef DSPMAC_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign accu_out  = accu_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dspmac_pipe.sv
// Bench for dspmac_pipe: 40-bit and 32-bit accumulator instances driven in lockstep,
// checked every cycle against an arithmetic model of issued operations.
module tb_dspmac_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic               in_valid;
    logic [2:0]         opcode;
    logic signed [15:0] a_in, b_in;
    logic signed [39:0] accu40;
    logic signed [31:0] accu32;
    logic               ov40, ov32, ovf40, ovf32;

    dspmac_pipe #(.A_W(16), .B_W(16), .ACC_W(40)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode),
        .a_in(a_in), .b_in(b_in), .accu_out(accu40), .out_valid(ov40), .ovf(ovf40)
    );

    dspmac_pipe #(.A_W(16), .B_W(16), .ACC_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode),
        .a_in(a_in), .b_in(b_in), .accu_out(accu32), .out_valid(ov32), .ovf(ovf32)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int     due;
        int     op;
        longint p;
    } ent_t;
    ent_t pend_q[$];

    longint m_acc40 = 0, m_acc32 = 0;
    bit     m_ovf40 = 0, m_ovf32 = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour of one completed op on a w-bit accumulator.
    task automatic model_op(input int op, input longint p, input int w,
                            inout longint acc, inout bit ovf);
        longint s;
`ifdef DSPMAC_SAT_EN
        longint lim_hi, lim_lo;
        lim_hi = (longint'(1) <<< (w - 1)) - 1;
        lim_lo = -(longint'(1) <<< (w - 1));
`endif
        case (op)
            0: begin acc = 0; ovf = 0; end
            1: acc = p;
            2, 4: begin
                s = (op == 2) ? acc + p : acc - p;
`ifdef DSPMAC_SAT_EN
                if (s > lim_hi) begin acc = lim_hi; ovf = 1; end
                else if (s < lim_lo) begin acc = lim_lo; ovf = 1; end
                else acc = s;
`else
                acc = (s <<< (64 - w)) >>> (64 - w);
`endif
            end
            default: ;
        endcase
    endtask

    task automatic check_cycle();
        ent_t e;
        if (pend_q.size() != 0 && pend_q[0].due == edge_cnt) begin
            e = pend_q.pop_front();
            model_op(e.op, e.p, 40, m_acc40, m_ovf40);
            model_op(e.op, e.p, 32, m_acc32, m_ovf32);
            check_val("out_valid40", ov40, 1);
            check_val("out_valid32", ov32, 1);
        end else begin
            check_val("out_valid40_idle", ov40, 0);
            check_val("out_valid32_idle", ov32, 0);
        end
        check_val("accu40", 64'(accu40), m_acc40);
        check_val("accu32", 64'(accu32), m_acc32);
        check_val("ovf40", ovf40, m_ovf40);
        check_val("ovf32", ovf32, m_ovf32);
    endtask

    task automatic issue(input bit v, input logic [2:0] op, input int a, input int b);
        ent_t e;
        @(negedge clk);
        check_cycle();
        in_valid = v;
        opcode   = op;
        a_in     = 16'(a);
        b_in     = 16'(b);
        if (v) begin
            e.due = edge_cnt + 3;
            e.op  = int'(op);
            e.p   = longint'(a_in) * longint'(b_in);
            pend_q.push_back(e);
        end
    endtask

    task automatic drain(input int n);
        repeat (n) issue(0, 3'($urandom_range(0, 7)),
                         int'($urandom_range(0, 65535)) - 32768,
                         int'($urandom_range(0, 65535)) - 32768);
    endtask

    function automatic int rand_operand();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return -32768;
        if (r == 1) return 32767;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        opcode   = 3'b000;
        a_in     = '0;
        b_in     = '0;
        #3;
        check_val("rst_accu40", 64'(accu40), 0);
        check_val("rst_accu32", 64'(accu32), 0);
        check_val("rst_out_valid", {ov40, ov32}, 0);
        check_val("rst_ovf", {ovf40, ovf32}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // MUL 3 * -5
        issue(1, 3'b001, 3, -5);
        drain(4);
        check_val("t1_accu", 64'(accu40), 64'(-15));

        // back-to-back MUL, MAC, MSU
        issue(1, 3'b001, 2, 3);
        issue(1, 3'b010, 4, 5);
        issue(1, 3'b100, 1, 7);
        drain(4);
        check_val("t2_accu", 64'(accu40), 64'd19);

        // MACs with bubbles in between
        issue(1, 3'b000, 0, 0);
        for (int i = 0; i < 4; i++) begin
            issue(1, 3'b010, 100, 100);
            issue(0, 3'b010, 100, 100);
        end
        drain(4);
        check_val("t3_accu", 64'(accu40), 64'd40000);

        // most-negative squared, then CLR right behind MACs
        issue(1, 3'b001, -32768, -32768);
        drain(3);
        check_val("t4_corner", 64'(accu40), 64'h40000000);
        issue(1, 3'b010, 1000, 1000);
        issue(1, 3'b010, -1000, 1000);
        issue(1, 3'b000, 5, 5);
        drain(4);
        check_val("t4_clr_accu", 64'(accu40), 0);
        check_val("t4_clr_ovf", ovf40, 0);

        // overflow of a 32-bit accumulator, sticky through NOP
        issue(1, 3'b001, -32768, -32768);
        issue(1, 3'b010, -32768, -32768);
        issue(1, 3'b011, 9, 9);
        drain(4);
        check_val("t5_accu40", 64'(accu40), 64'h80000000);
`ifdef DSPMAC_SAT_EN
        check_val("t5_accu32", {32'b0, accu32}, 64'h7FFFFFFF);
        check_val("t5_ovf32", ovf32, 1);
`else
        check_val("t5_accu32", {32'b0, accu32}, 64'h80000000);
        check_val("t5_ovf32", ovf32, 0);
`endif
        issue(1, 3'b000, 0, 0);
        drain(3);
        check_val("t5_clr_ovf32", ovf32, 0);

        // randomized traffic, including undefined opcodes and bubbles
        for (int i = 0; i < 400; i++) begin
            issue($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  rand_operand(), rand_operand());
        end
        drain(4);

        // reset with MACs in flight
        issue(1, 3'b001, 7, 9);
        drain(3);
        issue(1, 3'b010, 11, 13);
        issue(1, 3'b010, 11, 13);
        issue(1, 3'b010, 11, 13);
        @(negedge clk);
        check_cycle();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("t6_accu40", 64'(accu40), 0);
        check_val("t6_accu32", 64'(accu32), 0);
        check_val("t6_out_valid", {ov40, ov32}, 0);
        pend_q.delete();
        m_acc40 = 0;
        m_acc32 = 0;
        m_ovf40 = 0;
        m_ovf32 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drain(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
